ifetch_queued: RTL and testbench

//  Next-generation fetch stage: fetches FETCH_WIDTH instructions per I-cache hit, cuts the group at the

---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/ifetch_queued_fetch_queue.sv | 49 ++++
 rtl/ifetch_queued.sv | 144 ++++++++++++++
 tb/tb_ifetch_queued.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the queued fetch stage: queue entry layout, pending-redirect states
// and the derived counter/pointer widths.
package ifetch_pkg;
    localparam int PC_BITS      = 32;
    localparam int INSTR_BITS   = 32;
    localparam int FETCH_WIDTH  = 4;
    localparam int DEQ_WIDTH    = 2;
    localparam int QUEUE_DEPTH  = 8;

    localparam int CNT_BITS     = $clog2(FETCH_WIDTH + 1);
    localparam int DEQ_CNT_BITS = $clog2(DEQ_WIDTH + 1);
    localparam int QCNT_BITS    = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_BITS     = $clog2(QUEUE_DEPTH);
    localparam int SLOT_BITS    = $clog2(FETCH_WIDTH);

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] data;
        logic                  taken_branch;
    } fetch_entry_t;

    // Decode sees queue entries unchanged, so the output lane type is the entry type.
    typedef fetch_entry_t fetched_packet;

    localparam int PACKET_BITS = $bits(fetched_packet);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} pend_state_e;
endpackage

// File: rtl/ifetch_queued_fetch_queue.sv
// Circular fetch queue: accepts up to FETCH_WIDTH entries and releases up to DEQ_WIDTH per cycle;
// flush empties it in one cycle.
module fetch_queue
    import ifetch_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [CNT_BITS-1:0]              enq_cnt,
    input  fetch_entry_t [FETCH_WIDTH-1:0]   enq_data,
    input  logic [DEQ_CNT_BITS-1:0]          deq_cnt,
    output fetch_entry_t [DEQ_WIDTH-1:0]     head_data,
    output logic [QCNT_BITS-1:0]             count
);
    fetch_entry_t        mem [QUEUE_DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_BITS'(deq_cnt);
            tail  <= tail + PTR_BITS'(enq_cnt);
            count <= count + QCNT_BITS'(enq_cnt) - QCNT_BITS'(deq_cnt);
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (CNT_BITS'(i) < enq_cnt)
                    mem[tail + PTR_BITS'(i)] <= enq_data[i];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < DEQ_WIDTH; j++)
            head_data[j] = mem[head + PTR_BITS'(j)];
    end
endmodule

// File: rtl/ifetch_queued.sv
// Queued fetch stage: cuts each I-cache group at line end / first taken slot, buffers it and feeds decode.
// Optional IFETCH_BYPASS_EN lets a hit into an empty queue reach decode in the same cycle.
module ifetch_queued
    import ifetch_pkg::*;
#(
    parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [PC_BITS-1:0]                current_pc,
    output logic                              fetch_req,
    input  logic                              hit_cache,
    input  logic [CNT_BITS-1:0]               line_valid_cnt,
    input  logic [FETCH_WIDTH*INSTR_BITS-1:0] fetched_data,
    input  logic [FETCH_WIDTH-1:0]            pred_taken_vec,
    input  logic [PC_BITS-1:0]                pred_target,
    input  logic                              must_flush,
    input  logic [PC_BITS-1:0]                correct_address,
    input  logic                              invalid_prediction,
    input  logic [PC_BITS-1:0]                old_pc,
    output logic [DEQ_WIDTH*PACKET_BITS-1:0]  data_out,
    output logic [DEQ_WIDTH-1:0]              valid_o,
    input  logic                              ready_in
);
    logic                           redirect;
    logic [PC_BITS-1:0]             redirect_pc;
    logic                           accept;
    logic                           taken_in_group;
    logic [CNT_BITS-1:0]            taken_idx;
    logic [CNT_BITS-1:0]            group_n;
    logic [CNT_BITS-1:0]            lanes_n;
    logic [CNT_BITS-1:0]            enq_cnt;
    logic [DEQ_CNT_BITS-1:0]        deq_cnt;
    logic                           bypass;
    logic [QCNT_BITS-1:0]           q_count;
    fetch_entry_t [DEQ_WIDTH-1:0]   q_head;
    fetch_entry_t [FETCH_WIDTH-1:0] slots;
    fetch_entry_t [FETCH_WIDTH-1:0] enq_data;
    pend_state_e                    pend_state;
    logic [PC_BITS-1:0]             saved_pc;

    assign redirect    = must_flush | invalid_prediction;
    assign redirect_pc = must_flush ? correct_address : old_pc;
    assign fetch_req   = !rst && !redirect &&
                         (QCNT_BITS'(QUEUE_DEPTH) - q_count >= QCNT_BITS'(FETCH_WIDTH));
    assign accept      = fetch_req && hit_cache && (pend_state == IDLE);

    // A taken slot past the line end is not part of this group and does not redirect.
    always_comb begin
        taken_idx      = '0;
        taken_in_group = 1'b0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (pred_taken_vec[i] && (CNT_BITS'(i) < line_valid_cnt)) begin
                taken_in_group = 1'b1;
                taken_idx      = CNT_BITS'(i);
            end
        end
        group_n = taken_in_group ? taken_idx + CNT_BITS'(1) : line_valid_cnt;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slots[i].pc           = current_pc + PC_BITS'(4 * i);
            slots[i].data         = fetched_data[i*INSTR_BITS +: INSTR_BITS];
            slots[i].taken_branch = taken_in_group && (taken_idx == CNT_BITS'(i));
        end
    end

    always_comb begin
        bypass   = 1'b0;
        lanes_n  = (q_count >= QCNT_BITS'(DEQ_WIDTH)) ? CNT_BITS'(DEQ_WIDTH) : CNT_BITS'(q_count);
        enq_cnt  = accept ? group_n : '0;
        enq_data = slots;
`ifdef IFETCH_BYPASS_EN
        if (accept && (q_count == '0)) begin
            bypass  = 1'b1;
            lanes_n = (group_n >= CNT_BITS'(DEQ_WIDTH)) ? CNT_BITS'(DEQ_WIDTH) : group_n;
            if (ready_in) begin
                enq_cnt = group_n - lanes_n;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (i + int'(lanes_n) < FETCH_WIDTH)
                        enq_data[i] = slots[SLOT_BITS'(i) + SLOT_BITS'(lanes_n)];
                end
            end
        end
`endif
        if (redirect || (pend_state != IDLE))
            lanes_n = '0;
        deq_cnt = (ready_in && !bypass) ? DEQ_CNT_BITS'(lanes_n) : '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            valid_o[j] = CNT_BITS'(j) < lanes_n;
            data_out[j*PACKET_BITS +: PACKET_BITS] = bypass ? slots[j] : q_head[j];
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .enq_cnt   (enq_cnt),
        .enq_data  (enq_data),
        .deq_cnt   (deq_cnt),
        .head_data (q_head),
        .count     (q_count)
    );

    // A redirect during a miss is parked until the miss returns; a flush outranks a parked mispredict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_pc <= RESET_PC;
            pend_state <= IDLE;
            saved_pc   <= '0;
        end else begin
            case (pend_state)
                IDLE: begin
                    if (redirect) begin
                        if (hit_cache) begin
                            current_pc <= redirect_pc;
                        end else begin
                            saved_pc   <= redirect_pc;
                            pend_state <= must_flush ? HIGH : LOW;
                        end
                    end else if (accept) begin
                        current_pc <= taken_in_group ? pred_target
                                                     : current_pc + {group_n, 2'b00};
                    end
                end
                LOW: begin
                    if (hit_cache) begin
                        current_pc <= redirect ? redirect_pc : saved_pc;
                        pend_state <= IDLE;
                    end else if (must_flush) begin
                        saved_pc   <= correct_address;
                        pend_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (hit_cache) begin
                        current_pc <= redirect ? redirect_pc : saved_pc;
                        pend_state <= IDLE;
                    end
                end
                default: pend_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queued.sv
// Directed bench for ifetch_queued; the I-cache model returns TAG|pc for every slot.
// Expectations follow IFETCH_BYPASS_EN where the two builds differ.
module tb_ifetch_queued;
    import ifetch_pkg::*;

    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [PC_BITS-1:0]                current_pc;
    logic                              fetch_req;
    logic                              hit_cache;
    logic [CNT_BITS-1:0]               line_valid_cnt;
    logic [FETCH_WIDTH*INSTR_BITS-1:0] fetched_data;
    logic [FETCH_WIDTH-1:0]            pred_taken_vec;
    logic [PC_BITS-1:0]                pred_target;
    logic                              must_flush;
    logic [PC_BITS-1:0]                correct_address;
    logic                              invalid_prediction;
    logic [PC_BITS-1:0]                old_pc;
    logic [DEQ_WIDTH*PACKET_BITS-1:0]  data_out;
    logic [DEQ_WIDTH-1:0]              valid_o;
    logic                              ready_in;

    int testCount = 0;
    int failCount = 0;

    ifetch_queued dut (
        .clk                (clk),
        .rst                (rst),
        .current_pc         (current_pc),
        .fetch_req          (fetch_req),
        .hit_cache          (hit_cache),
        .line_valid_cnt     (line_valid_cnt),
        .fetched_data       (fetched_data),
        .pred_taken_vec     (pred_taken_vec),
        .pred_target        (pred_target),
        .must_flush         (must_flush),
        .correct_address    (correct_address),
        .invalid_prediction (invalid_prediction),
        .old_pc             (old_pc),
        .data_out           (data_out),
        .valid_o            (valid_o),
        .ready_in           (ready_in)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            fetched_data[i*INSTR_BITS +: INSTR_BITS] = TAG | (current_pc + 32'(4 * i));
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkLane(input string tag, input int j, input logic [31:0] expPc, input logic expTaken);
        fetch_entry_t e;
        e = data_out[j*PACKET_BITS +: PACKET_BITS];
        checkOutput({tag, "_pc"}, 64'(e.pc), 64'(expPc));
        checkOutput({tag, "_data"}, 64'(e.data), 64'(TAG | expPc));
        checkOutput({tag, "_taken"}, 64'(e.taken_branch), 64'(expTaken));
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
    task automatic applyStimulus(input logic hit, input logic rdy,
                                 input logic [CNT_BITS-1:0] lvc = 3'd4,
                                 input logic [FETCH_WIDTH-1:0] taken = '0,
                                 input logic [31:0] target = '0,
                                 input logic flush = 1'b0, input logic [31:0] corr = '0,
                                 input logic mispred = 1'b0, input logic [31:0] old = '0);
        @(negedge clk);
        hit_cache          = hit;
        ready_in           = rdy;
        line_valid_cnt     = lvc;
        pred_taken_vec     = taken;
        pred_target        = target;
        must_flush         = flush;
        correct_address    = corr;
        invalid_prediction = mispred;
        old_pc             = old;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst                = 1'b1;
        hit_cache          = 1'b0;
        ready_in           = 1'b0;
        line_valid_cnt     = 3'd4;
        pred_taken_vec     = '0;
        pred_target        = '0;
        must_flush         = 1'b0;
        correct_address    = '0;
        invalid_prediction = 1'b0;
        old_pc             = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_pc", 64'(current_pc), 64'h0);
        checkOutput("rst_req", 64'(fetch_req), 64'h0);
        checkOutput("rst_valid", 64'(valid_o), 64'h0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expPc;
        logic [1:0]  expValid;
        logic        expReq;

        // Streaming with decode always ready: two lanes per cycle in program order.
        resetDut();
        expPc = 32'h0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b1);
`ifdef IFETCH_BYPASS_EN
            expValid = 2'b11;
            expReq   = (c <= 2) || (c % 2 == 0);
`else
            expValid = (c == 0) ? 2'b00 : 2'b11;
            expReq   = (c == 0) || (c % 2 == 1);
`endif
            checkOutput("t1_valid", 64'(valid_o), 64'(expValid));
            checkOutput("t1_req", 64'(fetch_req), 64'(expReq));
            if (valid_o[0]) begin
                checkLane("t1_lane0", 0, expPc, 1'b0);
                checkLane("t1_lane1", 1, expPc + 32'd4, 1'b0);
                expPc += 32'd8;
            end
        end

        // Single instruction left in the line.
        resetDut();
        applyStimulus(1'b1, 1'b1, 3'd4, 4'b0, 32'h0, 1'b1, 32'h1C);
        checkOutput("t2_redir_valid", 64'(valid_o), 64'h0);
        checkOutput("t2_redir_req", 64'(fetch_req), 64'h0);
        applyStimulus(1'b1, 1'b0, 3'd1);
        checkOutput("t2_pc", 64'(current_pc), 64'h1C);
        checkOutput("t2_req", 64'(fetch_req), 64'h1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t2_next_pc", 64'(current_pc), 64'h20);
        checkOutput("t2_valid", 64'(valid_o), 64'h1);
        checkLane("t2_lane0", 0, 32'h1C, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t2_drained", 64'(valid_o), 64'h0);

        // Group cut at the first predicted-taken slot.
        resetDut();
        applyStimulus(1'b1, 1'b1, 3'd4, 4'b0, 32'h0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 3'd4, 4'b0110, 32'h200);
        checkOutput("t3_pc", 64'(current_pc), 64'h100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_target", 64'(current_pc), 64'h200);
        checkOutput("t3_valid", 64'(valid_o), 64'h3);
        checkLane("t3_lane0", 0, 32'h100, 1'b0);
        checkLane("t3_lane1", 1, 32'h104, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_drained", 64'(valid_o), 64'h0);

        // Decode stall: queue fills to 8, fetch stops, then drains in order.
        resetDut();
        for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0);
        checkOutput("t4_req", 64'(fetch_req), 64'h0);
        checkOutput("t4_pc", 64'(current_pc), 64'h20);
        checkOutput("t4_valid", 64'(valid_o), 64'h3);
        checkLane("t4_head", 0, 32'h0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b1, 1'b1);
            checkLane("t4_drain0", 0, 32'(8 * r), 1'b0);
            checkLane("t4_drain1", 1, 32'(8 * r + 4), 1'b0);
            if (r <= 2) checkOutput("t4_drain_req", 64'(fetch_req), 64'(r == 2));
        end

        // Mispredict then flush during a miss: the flush target wins and the hit is dropped.
        resetDut();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd4, 4'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40);
        checkOutput("t5_mp_valid", 64'(valid_o), 64'h0);
        checkOutput("t5_mp_req", 64'(fetch_req), 64'h0);
        applyStimulus(1'b0, 1'b1, 3'd4, 4'b0, 32'h0, 1'b1, 32'h80);
        checkOutput("t5_fl_valid", 64'(valid_o), 64'h0);
        checkOutput("t5_fl_pc", 64'(current_pc), 64'h10);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5_hit_pc", 64'(current_pc), 64'h10);
        checkOutput("t5_hit_valid", 64'(valid_o), 64'h0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_new_pc", 64'(current_pc), 64'h80);
        checkOutput("t5_empty", 64'(valid_o), 64'h0);

        // Latency from a hit into an empty queue.
        resetDut();
        applyStimulus(1'b1, 1'b1);
`ifdef IFETCH_BYPASS_EN
        checkOutput("t6_same_valid", 64'(valid_o), 64'h3);
        checkLane("t6_same_lane0", 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_next_valid", 64'(valid_o), 64'h3);
        checkLane("t6_next_lane0", 0, 32'h8, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_drained", 64'(valid_o), 64'h0);
`else
        checkOutput("t6_same_valid", 64'(valid_o), 64'h0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_next_valid", 64'(valid_o), 64'h3);
        checkLane("t6_next_lane0", 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkLane("t6_last_lane1", 1, 32'hC, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
